// File: rtl/memory_bus_interface_pkg.sv
// Shared CPU definitions: bus width, memory-interface FSM states and data-bus
// select codes used by the mux and the control unit.
package memory_bus_interface_pkg;

    localparam int unsigned BUS_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mbi_state_e;

    typedef enum logic [1:0] {
        BUS_SEL_ALU = 2'b00,
        BUS_SEL_MEM = 2'b01,
        BUS_SEL_RF  = 2'b10
    } bus_sel_e;

endpackage

// File: rtl/memory_bus_interface_bus_timeout_counter.sv
// Counts cycles while enabled; expired is high in the TIMEOUT-th enabled
// cycle after a clear.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_bus_interface.sv
// Single-word read/write sequencer between the CPU data bus and word-addressed
// memory, with req/ack handshake, MDR and timeout abort.
module memory_bus_interface
    import memory_bus_interface_pkg::*;
#(
    parameter int unsigned DATA_W  = BUS_DATA_W,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_rd,
    input  logic              start_wr,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] mdr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    mbi_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              expired;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr_in[DATA_W-1:ADDR_W];

    bus_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_REQ),
        .enable (state_q == ST_REQ),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rd || start_wr) begin
                    addr_d  = addr_in[ADDR_W-1:0];
                    wdata_d = wdata_in;
                    we_d    = start_wr;
                    err_d   = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack takes priority over an expiry in the same cycle
                if (mem_ack) begin
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // status outputs are registered, so decode them from the next state
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        req_d  = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mdr_data  = mdr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_req   = req_q;

endmodule
